// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/memory types.
//   word_t      - 32-bit machine word used for addresses and data.
//   ramstate_t  - status reported by the RAM model each cycle.
//   arb_state_t - ram_arbiter FSM state.
//   arb_gnt_t   - granted requester: CPU id plus instruction/data select.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    IDLE,
    XFER
  } arb_state_t;

  typedef struct packed {
    logic cpu;
    logic isdata;
  } arb_gnt_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational requester picker for ram_arbiter.
// Ports:
//   dreq_i     - per-CPU data request (dREN | dWEN).
//   ireq_i     - per-CPU instruction request.
//   last_cpu_i - CPU served by the most recent completed transfer.
//   gnt_o      - chosen requester (valid only when valid_o is high).
//   valid_o    - at least one requester is asserting.
// Data beats instruction within a CPU; across CPUs the one that was not
// served last wins a tie.
module rr_pick
  import cpu_types_pkg::*;
(
  input  logic [1:0] dreq_i,
  input  logic [1:0] ireq_i,
  input  logic       last_cpu_i,
  output arb_gnt_t   gnt_o,
  output logic       valid_o
);

  logic [1:0] cpu_req;
  logic       win_cpu;

  always_comb begin
    cpu_req = dreq_i | ireq_i;
    valid_o = |cpu_req;
    if (&cpu_req) begin
      win_cpu = ~last_cpu_i;
    end else begin
      // Only one CPU (or none) requests; CPU1 iff its bit is set.
      win_cpu = cpu_req[1];
    end
    gnt_o.cpu    = win_cpu;
    gnt_o.isdata = dreq_i[win_cpu];
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates the two CPUs' instruction and data cache ports
// onto the single shared RAM port.
// Ports:
//   CLK, RST             - clock, synchronous active-high reset.
//   iREN, iaddr          - per-CPU instruction read request and address.
//   dREN, dWEN           - per-CPU data read / write request.
//   daddr, dstore        - per-CPU data address and write value.
//   iwait, dwait         - per-CPU stalls; low only in the completing cycle.
//   iload, dload         - read data back to the caches (copies of ramload).
//   ramREN, ramWEN       - RAM strobes.
//   ramaddr, ramstore    - RAM address and write data.
//   ramload, ramstate    - RAM read data and status.
//   gnt_cnt              - saturating count of completed transfers per CPU.
// A grant is latched in IDLE; in XFER the RAM port is driven straight from
// the granted requester's live inputs until the RAM reports ACCESS. Every
// completion is followed by one IDLE cycle for rearbitration.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            iREN,
  input  word_t [1:0]           iaddr,
  input  logic [1:0]            dREN,
  input  logic [1:0]            dWEN,
  input  word_t [1:0]           daddr,
  input  word_t [1:0]           dstore,
  output logic [1:0]            iwait,
  output logic [1:0]            dwait,
  output word_t [1:0]           iload,
  output word_t [1:0]           dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  input  word_t                 ramload,
  input  ramstate_t             ramstate,
  output logic [1:0][CNT_W-1:0] gnt_cnt
);

  arb_state_t            state_q;
  arb_gnt_t              gnt_q;
  logic                  last_cpu_q;
  logic [1:0][CNT_W-1:0] cnt_q;

  logic [1:0] dreq;
  arb_gnt_t   pick_gnt;
  logic       pick_valid;
  logic       gnt_req;
  logic       xfer_act;
  logic       done;

  assign dreq = dREN | dWEN;

  rr_pick u_rr_pick (
    .dreq_i    (dreq),
    .ireq_i    (iREN),
    .last_cpu_i(last_cpu_q),
    .gnt_o     (pick_gnt),
    .valid_o   (pick_valid)
  );

  // Granted requester still asserting its live request.
  always_comb begin
    if (gnt_q.isdata) begin
      gnt_req = dreq[gnt_q.cpu];
    end else begin
      gnt_req = iREN[gnt_q.cpu];
    end
  end

  // RST gates the port combinationally so a reset mid-transfer drops the
  // strobes in the very cycle it is asserted.
  assign xfer_act = (state_q == XFER) && gnt_req && !RST;
  assign done     = xfer_act && (ramstate == ACCESS);

  // RAM port mux and wait release.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 2'b11;
    dwait    = 2'b11;
    if (xfer_act) begin
      if (gnt_q.isdata) begin
        // Write wins when both data strobes are high.
        ramWEN   = dWEN[gnt_q.cpu];
        ramREN   = dREN[gnt_q.cpu] & ~dWEN[gnt_q.cpu];
        ramaddr  = daddr[gnt_q.cpu];
        ramstore = dstore[gnt_q.cpu];
        if (done) begin
          dwait[gnt_q.cpu] = 1'b0;
        end
      end else begin
        ramREN  = 1'b1;
        ramaddr = iaddr[gnt_q.cpu];
        if (done) begin
          iwait[gnt_q.cpu] = 1'b0;
        end
      end
    end
  end

  assign iload[0] = ramload;
  assign iload[1] = ramload;
  assign dload[0] = ramload;
  assign dload[1] = ramload;
  assign gnt_cnt  = cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_cpu_q <= 1'b1;  // CPU0 wins the first tie
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q   <= pick_gnt;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (!gnt_req) begin
            // Requester withdrew: abandon without counting.
            state_q <= IDLE;
          end else if (ramstate == ACCESS) begin
            state_q    <= IDLE;
            last_cpu_q <= gnt_q.cpu;
            if (cnt_q[gnt_q.cpu] != {CNT_W{1'b1}}) begin
              cnt_q[gnt_q.cpu] <= cnt_q[gnt_q.cpu] + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Dual-core RAM arbiter between the two CPUs' instruction and data cache ports and the single shared RAM port. It picks one of four requesters, holds the RAM request stable until the RAM reports `ACCESS`, then releases that requester's wait. It keeps per-CPU grant counters for performance monitoring. It replaces the single-CPU pass-through memory controller when the second core is instantiated; coherence snooping is out of scope.

## Interface
Parameters:
- `CNT_W`, 16: width of each per-CPU grant counter.

Ports (all `[1:0]` arrays are indexed by CPU id):
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `iREN`  in  [1:0]  instruction read request.
- `iaddr`  in  2x`word_t`  instruction address.
- `dREN`  in  [1:0]  data read request.
- `dWEN`  in  [1:0]  data write request.
- `daddr`  in  2x`word_t`  data address.
- `dstore`  in  2x`word_t`  data write value.
- `iwait`  out  [1:0]  instruction stall; low for exactly the completing cycle.
- `dwait`  out  [1:0]  data stall; low for exactly the completing cycle.
- `iload`  out  2x`word_t`  equals `ramload`.
- `dload`  out  2x`word_t`  equals `ramload`.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  `word_t`  RAM address.
- `ramstore`  out  `word_t`  RAM write data.
- `ramload`  in  `word_t`  RAM read data.
- `ramstate`  in  `ramstate_t`  one of FREE, BUSY, ACCESS, ERROR.
- `gnt_cnt`  out  2x`CNT_W`  completed transfers per CPU.

## Operation
- Requesters: d0, i0, d1, i1. Request is `dREN|dWEN` for data, `iREN` for instruction.
- Priority inside a CPU: data over instruction.
- Priority across CPUs: round-robin on `last_cpu`, the CPU served by the most recent completed transfer. The other CPU wins when both request.
- FSM with two states:
  - IDLE: no RAM strobes. Any request latches `gnt` (CPU id plus i/d select) and moves to XFER. No request stays in IDLE.
  - XFER: `ramaddr`, `ramstore`, `ramREN`, `ramWEN` are driven combinationally from the live inputs of the granted requester.
    - `ramstate==ACCESS`: granted wait low this cycle, `last_cpu<=gnt cpu`, `gnt_cnt[cpu]` increments, next state IDLE.
    - FREE, BUSY or ERROR: all waits stay high; remain in XFER (ERROR retries indefinitely).
    - Granted request drops (abort): next state IDLE; no count, `last_cpu` unchanged.
- Data requester with `dWEN` and `dREN` both high: write. `ramWEN=1`, `ramREN=0`, `ramaddr=daddr`.
- Instruction requester: `ramREN=1`, `ramWEN=0`, `ramaddr=iaddr`, `ramstore=0`.
- Non-granted requesters: wait held at 1.
- `gnt_cnt` saturates at all-ones.
- Reset:
  - While `RST` is high, combinationally force `ramREN=ramWEN=0` and all waits 1.
  - Next edge: state IDLE, `last_cpu=1` (CPU0 wins first tie), `gnt=0`, `gnt_cnt=0`.
  - Reset during XFER abandons the transfer with no count.
- Outputs at reset/IDLE: `ramaddr=0`, `ramstore=0`, strobes 0, waits 1.

## Timing
- Request seen in IDLE at cycle N gives XFER at N+1.
- Earliest completion at N+1 if the RAM returns ACCESS immediately. Otherwise completion is the first ACCESS cycle.
- After completion one IDLE cycle follows (rearbitration bubble). Back-to-back transfers are therefore at least 2 cycles apart.
- The wait release is combinational from `ramstate` in the same cycle. The cache samples `load` on that edge.
- Requests are level-sensitive. A requester must hold address/data stable until its wait drops; the arbiter does not latch them.

## Structure
- `cpu_types_pkg` supplies `word_t` and `ramstate_t`.
- Add to `cpu_types_pkg`:
  - `arb_state_t` {IDLE, XFER};
  - `arb_gnt_t` struct {logic cpu; logic isdata}.
- Natural sub-module: `rr_pick`, a combinational picker. Inputs: the 4 request bits and `last_cpu`. Output: `arb_gnt_t` plus a valid bit.
- The FSM, counters and mux live in `ram_arbiter`.

## Test plan
- Reset, then single `iREN[0]` with `iaddr=0x100`, RAM returns ACCESS 3 cycles into XFER:
  - `ramREN=1`, `ramaddr=0x100` during XFER;
  - `iwait[0]` low for exactly 1 cycle;
  - `gnt_cnt[0]=1`.
- `dREN[0]` and `iREN[0]` together, addresses 0x200/0x100: data is served first (`ramaddr=0x200`), then the bubble, then the instruction fetch at 0x100.
- Both CPUs hold `dWEN` continuously (CPU1 `dstore=0xBEEF`), RAM always ACCESS:
  - grants alternate CPU0, CPU1, CPU0…;
  - `ramstore=0xBEEF` on CPU1 grants;
  - after 10 transfers `gnt_cnt` is 5/5.
- RAM returns ERROR for 4 cycles, then ACCESS: all waits stay high through ERROR; one completion; count +1.
- `RST` asserted mid-XFER while `ramstate` is BUSY:
  - strobes drop that cycle;
  - state IDLE, counters 0;
  - next tie goes to CPU0.
- Preload `gnt_cnt[1]` to max via forced transfers, then one more CPU1 transfer: counter holds all-ones.
